// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// default reset PC and the canonical NOP word.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at a
// time, buffers the returned word for decode and honours trap/flush redirects.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      pc,
    input  logic [31:0]      pc_next,
    input  logic             flush,
    input  logic [31:0]      flush_pc,
    output logic             imem_req_valid,
    output logic [31:0]      imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_resp_valid,
    input  logic [31:0]      imem_resp_data,
    output logic             inst_valid,
    output logic [31:0]      inst,
    output logic [31:0]      inst_pc,
    input  logic             inst_ready,
    output logic [CNT_W-1:0] fetch_count
);

    fetch_state_t     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      inst_q, inst_d;
    logic [31:0]      inst_pc_q, inst_pc_d;
    logic             kill_q, kill_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
            kill_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            kill_q    <= kill_d;
            count_q   <= count_d;
        end
    end

    // kill marks an already-accepted request whose response must be swallowed.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        kill_d    = kill_q;
        count_d   = count_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (flush) pc_d = flush_pc;
            end
            S_REQ: begin
                if (flush) pc_d = flush_pc;
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                    kill_d  = flush;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    pc_d = flush_pc;
                    if (imem_resp_valid) begin
                        state_d = S_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d    = imem_resp_data;
                        inst_pc_d = pc_q;
                        state_d   = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (flush) begin
                    pc_d    = flush_pc;
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    pc_d    = pc_next;
                    count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pc             = pc_q;
    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (state_q == S_HOLD);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, backpressure, flush
// in WAIT/HOLD, reset mid-transaction and 4-bit counter wrap.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic [3:0]  fetch_count;

    logic        use_inc = 1'b1;
    logic [31:0] pc_next_fixed = '0;
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  exp_count = '0;

    assign pc_next = use_inc ? pc + 32'd4 : pc_next_fixed;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_next(pc_next),
        .flush(flush), .flush_pc(flush_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .inst_valid(inst_valid),
        .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .fetch_count(fetch_count)
    );

    task automatic cycle(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic req_ready, input logic resp_valid,
                                 input logic [31:0] resp_data, input logic ready,
                                 input logic fl, input logic [31:0] fl_pc);
        imem_req_ready  = req_ready;
        imem_resp_valid = resp_valid;
        imem_resp_data  = resp_data;
        inst_ready      = ready;
        flush           = fl;
        flush_pc        = fl_pc;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Starts in S_REQ; fetches one word at exp_addr with zero-wait memory and retires it.
    task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] data);
        checkOutput("req_valid", {31'b0, imem_req_valid}, 32'd1);
        checkOutput("req_addr", imem_req_addr, exp_addr);
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
        cycle();
        applyStimulus(1'b1, 1'b1, data, 1'b1, 1'b0, '0);
        cycle();
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
        checkOutput("hold_valid", {31'b0, inst_valid}, 32'd1);
        checkOutput("hold_inst", inst, data);
        checkOutput("hold_inst_pc", inst_pc, exp_addr);
        cycle();
        exp_count = exp_count + 4'd1;
        checkOutput("count", {28'b0, fetch_count}, {28'b0, exp_count});
    endtask

    initial begin
        logic [31:0] held_inst;

        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        cycle(2);
        checkOutput("rst_pc", pc, 32'h0);
        checkOutput("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        checkOutput("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        checkOutput("rst_count", {28'b0, fetch_count}, 32'd0);
        checkOutput("rst_inst", inst, 32'h0);
        rst = 1'b0;
        cycle();

        // Sequential fetch 0,4,8,0xC then 0x10 under backpressure
        for (int i = 0; i < 4; i++) fetch_one(32'(4 * i), NOP_INST + 32'(i << 8));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
            cycle();
            checkOutput("bp_req_valid", {31'b0, imem_req_valid}, 32'd1);
            checkOutput("bp_addr", imem_req_addr, 32'h10);
        end
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        cycle();
        applyStimulus(1'b1, 1'b1, 32'hCAFE_0010, 1'b0, 1'b0, '0);
        cycle();
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        held_inst = 32'hCAFE_0010;
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_inst_valid", {31'b0, inst_valid}, 32'd1);
            checkOutput("stall_inst", inst, held_inst);
            checkOutput("stall_inst_pc", inst_pc, 32'h10);
            checkOutput("stall_no_req", {31'b0, imem_req_valid}, 32'd0);
            cycle();
        end
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
        cycle();
        exp_count = exp_count + 4'd1;
        checkOutput("stall_count", {28'b0, fetch_count}, {28'b0, exp_count});
        checkOutput("stall_next_addr", imem_req_addr, 32'h14);

        // Flush in WAIT, stale response two cycles later
        cycle();
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, 32'h80);
        cycle();
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput("flw_pc", pc, 32'h80);
        checkOutput("flw_req_valid", {31'b0, imem_req_valid}, 32'd0);
        cycle();
        applyStimulus(1'b1, 1'b1, 32'h0000_DEAD, 1'b0, 1'b0, '0);
        cycle();
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput("flw_inst_valid", {31'b0, inst_valid}, 32'd0);
        checkOutput("flw_inst_not_dead", inst, 32'hCAFE_0010);
        fetch_one(32'h80, 32'h1234_5678);

        // Flush coincident with inst_ready in HOLD
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        cycle();
        applyStimulus(1'b1, 1'b1, 32'hAAAA_5555, 1'b0, 1'b0, '0);
        cycle();
        use_inc = 1'b0;
        pc_next_fixed = 32'h24;
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1, 32'h100);
        cycle();
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        use_inc = 1'b1;
        checkOutput("flh_pc", pc, 32'h100);
        checkOutput("flh_count", {28'b0, fetch_count}, {28'b0, exp_count});
        checkOutput("flh_req_addr", imem_req_addr, 32'h100);

        // Reset mid-WAIT, then responses in IDLE/REQ ignored
        cycle();
        rst = 1'b1;
        cycle();
        checkOutput("rw_pc", pc, 32'h0);
        checkOutput("rw_req_valid", {31'b0, imem_req_valid}, 32'd0);
        checkOutput("rw_inst_valid", {31'b0, inst_valid}, 32'd0);
        checkOutput("rw_count", {28'b0, fetch_count}, 32'd0);
        checkOutput("rw_inst", inst, 32'h0);
        checkOutput("rw_inst_pc", inst_pc, 32'h0);
        exp_count = '0;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'h0000_0BAD, 1'b0, 1'b0, '0);
        cycle();
        checkOutput("rw_req_after", {31'b0, imem_req_valid}, 32'd1);
        checkOutput("rw_addr_after", imem_req_addr, 32'h0);
        cycle();
        checkOutput("rw_resp_ignored", {31'b0, inst_valid}, 32'd0);
        checkOutput("rw_still_req", {31'b0, imem_req_valid}, 32'd1);

        // 17 retires on a 4-bit counter wraps to 1
        for (int i = 0; i < 17; i++) fetch_one(32'(4 * i), 32'h0100_0000 + 32'(i));
        checkOutput("wrap_count", {28'b0, fetch_count}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
